// File: rtl/redux_pkg.sv
// Shared types and constants for the Redux-V control path.
// Covers FSM state codes, PC source select codes and the opcodes the sequencer inspects.
package redux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  // States that hold a memory request open and are covered by the timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts request cycles without an acknowledge.
// Flags expiry on the MAX_WAIT-th cycle that still has no ack.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic ack,
  output logic expired
);

  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (!ack && (cnt_reg != LAST)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  // An ack on the final allowed cycle still wins over the timeout.
  assign expired = !ack && (cnt_reg == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory sequencer for the Redux-V core.
// Turns decoder levels into single-cycle strobes and guards memory waits with a timeout.
module cpu_sequencer
  import redux_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic [3:0]       opcode,
  input  logic             dec_we,
  input  logic             dec_re,
  input  logic             dec_b,
  input  logic             dec_j,
  input  logic             br_taken,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic             dmem_we,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           state_reg;
  state_t           state_next;
  logic             mem_req_reg;
  logic             addr_sel_reg;
  logic             busy_reg;
  logic             fault_reg;
  logic [CNT_W-1:0] instr_cnt_reg;
  logic             retire;
  logic             timer_clear;
  logic             timer_expired;
  state_t           retire_dest;
  logic             exec_is_br;
  logic             exec_is_jmp;

  // Branch/jump are identified by opcode; the decoder's b/j levels must agree.
  assign exec_is_br  = (opcode == OP_BR)  || (dec_b && (opcode == OP_BR));
  assign exec_is_jmp = (opcode == OP_JMP) || (dec_j && (opcode == OP_JMP));

  assign retire_dest = halt_req ? ST_HALT : ST_FETCH;

  // Ack-qualified and EXEC strobes, decoded from the registered state.
  always_comb begin
    pc_we  = 1'b0;
    pc_sel = PC_INC;
    rf_we  = 1'b0;
    retire = 1'b0;
    case (state_reg)
      ST_EXEC: begin
        if (!is_mem_op(opcode)) begin
          retire = 1'b1;
          pc_we  = 1'b1;
          if (exec_is_br) begin
            pc_sel = br_taken ? PC_BR : PC_INC;
          end else if (exec_is_jmp) begin
            pc_sel = PC_JMP;
          end else begin
            rf_we = dec_re;
          end
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          retire = 1'b1;
          pc_we  = 1'b1;
          rf_we  = (opcode == OP_LD);
        end
      end
      default: begin
        retire = 1'b0;
      end
    endcase
  end

  assign ir_we   = (state_reg == ST_FETCH) && mem_ack;
  assign dmem_we = (state_reg == ST_MEM) && dec_we;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_HALT: if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack)            state_next = ST_DECODE;
        else if (timer_expired) state_next = ST_FAULT;
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   state_next = is_mem_op(opcode) ? ST_MEM : retire_dest;
      ST_MEM: begin
        if (mem_ack)            state_next = retire_dest;
        else if (timer_expired) state_next = ST_FAULT;
      end
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Any state change restarts the wait count, so FETCH and MEM each start from zero.
  assign timer_clear = (state_next != state_reg) || !is_wait_state(state_reg);

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .ack    (mem_ack),
    .expired(timer_expired)
  );

  // Level outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      mem_req_reg   <= 1'b0;
      addr_sel_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      fault_reg     <= 1'b0;
      instr_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      mem_req_reg  <= is_wait_state(state_next);
      addr_sel_reg <= (state_next == ST_MEM);
      busy_reg     <= (state_next == ST_FETCH) || (state_next == ST_DECODE) ||
                      (state_next == ST_EXEC)  || (state_next == ST_MEM);
      fault_reg    <= fault_reg || (state_next == ST_FAULT);
      if (retire) begin
        instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign mem_req   = mem_req_reg;
  assign addr_sel  = addr_sel_reg;
  assign busy      = busy_reg;
  assign fault     = fault_reg;
  assign state     = state_reg;
  assign instr_cnt = instr_cnt_reg;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the Redux-V core.
- Sequences fetch, decode, execute and memory access around the combinational opcode decoder, the ALU and the unified memory port.
- Turns the decoder's static levels (we, re, b_mx, j_mx) into one-cycle write strobes and PC-update commands.
- Waits on a memory req/ack handshake, with a bounded timeout.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- MAX_WAIT, 15, maximum cycles spent waiting for mem_ack before fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE/HALT and begin fetching.
- halt_req  in  1  stop at the next instruction boundary.
- opcode  in  4  IR[7:4], valid from DECODE onward.
- dec_we  in  1  decoder store indication.
- dec_re  in  1  decoder register-write indication.
- dec_b  in  1  decoder branch indication (b_mx).
- dec_j  in  1  decoder jump indication (j_mx).
- br_taken  in  1  branch condition from the datapath.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_req  out  1  memory request, held high until ack.
- addr_sel  out  1  0 = PC address, 1 = data address.
- ir_we  out  1  instruction register load strobe.
- pc_we  out  1  PC write strobe.
- pc_sel  out  2  00 = PC+1, 01 = branch target, 10 = jump target.
- rf_we  out  1  register file write strobe.
- dmem_we  out  1  memory write enable, valid with mem_req.
- busy  out  1  high in FETCH, DECODE, EXEC, MEM.
- fault  out  1  sticky memory-timeout flag.
- state  out  3  current state encoding, for debug.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All strobes, mem_req, addr_sel, pc_sel, busy and fault are 0.
  - instr_cnt=0 and the wait counter=0.
  - Reset mid-handshake drops mem_req immediately; a late ack is ignored.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=5, FAULT=6.
- IDLE: start=1 -> FETCH.
- FETCH:
  - mem_req=1, addr_sel=0.
  - On mem_ack: ir_we=1 for that cycle -> DECODE.
- DECODE: one cycle, no strobes -> EXEC.
- EXEC (one cycle), selected by opcode:
  - 0000 (branch): pc_we=1, pc_sel=01 if br_taken else 00; retire.
  - 0001 (jump): pc_we=1, pc_sel=10; retire.
  - 0010 (load) and 0011 (store): -> MEM, no strobes yet.
  - All others (ALU ops): rf_we=dec_re, pc_we=1, pc_sel=00; retire.
- MEM:
  - mem_req=1, addr_sel=1, dmem_we=dec_we.
  - On mem_ack: rf_we=1 for load only, pc_we=1, pc_sel=00; retire.
- Retire:
  - instr_cnt increments and wraps at 2^CNT_W-1 -> 0.
  - Next state is HALT if halt_req=1 on the retire cycle, else FETCH.
- halt_req asserted anywhere else is not latched; it must be held until retire.
- HALT: busy=0; start=1 -> FETCH. instr_cnt is held.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - When it reaches MAX_WAIT with no ack: fault=1, mem_req=0 -> FAULT.
  - An ack arriving on the same cycle the counter reaches MAX_WAIT counts as success.
- FAULT is terminal; only rst_n exits it.
- Latencies:
  - ALU/branch/jump instruction: 3 cycles + fetch wait.
  - Load/store: 4 cycles + both waits.
  - With a zero-wait memory (ack in the first request cycle): ALU op = 3 cycles, load = 4 cycles.
- Strobes are registered Moore outputs except ir_we, rf_we and pc_we in FETCH/MEM, which are ack-qualified.
- No strobe is ever asserted for two consecutive cycles.
- mem_ack outside FETCH/MEM is ignored.
- dec_* inputs are sampled only in EXEC/MEM; X on them elsewhere is legal.

Decomposition:
- Package redux_pkg holds:
  - the state enum (7 codes, 3 bits);
  - the pc_sel codes PC_INC, PC_BR, PC_JMP;
  - the opcode constants OP_BR=0000, OP_JMP=0001, OP_LD=0010, OP_ST=0011.
- One sub-module, mem_wait_timer: wait counter plus timeout compare. Inputs: clear, ack. Output: expired.

Test Plan:
- ALU op (opcode 1000, dec_re=1), ack on the first request cycle -> ir_we@c1, rf_we and pc_we (pc_sel=00)@c3; instr_cnt 0->1; back in FETCH@c4.
- Branch (opcode 0000) with br_taken=1, then with br_taken=0 -> pc_sel=01, then 00, each with a single pc_we pulse; rf_we stays 0.
- Store (opcode 0011), data ack delayed 3 cycles -> mem_req and addr_sel=1 and dmem_we held high for 4 cycles; pc_we on the ack cycle; rf_we never asserted.
- Load, no ack for MAX_WAIT=15 cycles -> fault=1, mem_req=0, state=6; start ignored; rst_n pulse -> state=0, fault=0.
- halt_req held during an ALU op -> state=5 after retire, busy=0; start -> FETCH. Separately, rst_n asserted in MEM -> outputs 0 asynchronously, and a later ack causes no strobe.
